// File: rtl/sum_window_pkg.sv
// Shared types and default widths for the windowed sum accumulator.
package sum_window_pkg;

  localparam int SW_DATAWIDTH = 32;
  localparam int SW_ACCWIDTH  = 40;
  localparam int SW_CNTWIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sum_window_add.sv
// Accumulator adder: acc + zero-extended sample, combinational.
// SUM_WINDOW_SAT_EN: clamp at all-ones and flag overflow; otherwise wrap, ovf=0.
module sum_window_add
  import sum_window_pkg::*;
#(
  parameter int DATAWIDTH = SW_DATAWIDTH,
  parameter int ACCWIDTH  = SW_ACCWIDTH
) (
  input  logic [ACCWIDTH-1:0]  acc,
  input  logic [DATAWIDTH-1:0] sample,
  output logic [ACCWIDTH-1:0]  sum,
  output logic                 ovf
);

  logic [ACCWIDTH-1:0] ext;

  assign ext = ACCWIDTH'(sample);

`ifdef SUM_WINDOW_SAT_EN
  logic [ACCWIDTH:0] full;

  assign full = {1'b0, acc} + {1'b0, ext};
  // A saturated acc plus zero stays all-ones, so saturation holds naturally.
  assign ovf  = full[ACCWIDTH];
  assign sum  = ovf ? '1 : full[ACCWIDTH-1:0];
`else
  assign sum = acc + ext;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/sum_window_accum.sv
// Windowed accumulator: sums win_len samples, tracks max, holds result until taken.
// Build option SUM_WINDOW_SAT_EN selects saturating accumulation with sticky out_ovf.
module sum_window_accum
  import sum_window_pkg::*;
#(
  parameter int DATAWIDTH = SW_DATAWIDTH,
  parameter int ACCWIDTH  = SW_ACCWIDTH,
  parameter int CNTWIDTH  = SW_CNTWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [CNTWIDTH-1:0]  win_len,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACCWIDTH-1:0]  out_sum,
  output logic [DATAWIDTH-1:0] out_max,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [CNTWIDTH-1:0]  len, cnt, cnt_inc;
  logic [ACCWIDTH-1:0]  acc, add_sum;
  logic [DATAWIDTH-1:0] mx, mx_nxt;
  logic                 ovf, add_ovf, ovf_nxt;
  logic                 accept, last, go;

  assign go      = start && (win_len != '0);
  assign accept  = in_valid && (state == ACCUM);
  assign cnt_inc = cnt + CNTWIDTH'(1);
  assign last    = accept && (cnt_inc == len);
  assign mx_nxt  = (in_data > mx) ? in_data : mx;
  assign ovf_nxt = ovf | add_ovf;

  sum_window_add #(
    .DATAWIDTH (DATAWIDTH),
    .ACCWIDTH  (ACCWIDTH)
  ) u_add (
    .acc    (acc),
    .sample (in_data),
    .sum    (add_sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go)        state_nxt = ACCUM;
      ACCUM:   if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      len     <= '0;
      cnt     <= '0;
      acc     <= '0;
      mx      <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_max <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            len <= win_len;
            cnt <= '0;
            acc <= '0;
            mx  <= '0;
            ovf <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= add_sum;
            mx  <= mx_nxt;
            cnt <= cnt_inc;
            ovf <= ovf_nxt;
            // Result registers only move on the closing sample, so DONE holds them.
            if (last) begin
              out_sum <= add_sum;
              out_max <= mx_nxt;
              out_ovf <= ovf_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sum_window_accum.sv
// Randomized scoreboard bench for sum_window_accum (ACCWIDTH=32 to reach overflow).
module tb_sum_window_accum;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [CW-1:0] win_len;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [AW-1:0] out_sum;
  logic [DW-1:0] out_max;
  logic          out_ovf, out_valid, out_ready, busy;

  always #5 Clk = ~Clk;

  sum_window_accum #(.DATAWIDTH(DW), .ACCWIDTH(AW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .win_len(win_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_sum(out_sum), .out_max(out_max), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct {
    longint unsigned sum;
    longint unsigned mx;
    bit              ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   noq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: true window total, then clamp or wrap to AW bits.
  function automatic exp_t model(input longint unsigned s[$]);
    exp_t            e;
    longint unsigned tot = 0;
    longint unsigned lim = (64'd1 << AW) - 1;
    e.mx = 0;
    foreach (s[i]) begin
      tot += s[i];
      if (s[i] > e.mx) e.mx = s[i];
    end
`ifdef SUM_WINDOW_SAT_EN
    e.sum = (tot > lim) ? lim : tot;
    e.ovf = (tot > lim);
`else
    e.sum = tot & lim;
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum", out_sum, e.sum);
        check("out_max", out_max, e.mx);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  task automatic run_window(input int len, input longint unsigned s[$], input int gaps[$],
                            input int gap_max, input int hold);
    int g;
    exp_q.push_back(model(s));
    @(posedge Clk); #1;
    start   = 1'b1;
    win_len = CW'(len);
    @(posedge Clk); #1;
    start   = 1'b0;
    win_len = CW'($urandom);
    check("in_ready_after_start", in_ready, 1);
    for (int i = 0; i < s.size(); i++) begin
      g = (i < gaps.size()) ? gaps[i] : $urandom_range(0, gap_max);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        start    = 1'($urandom_range(0, 1));
        win_len  = CW'($urandom);
        @(posedge Clk); #1;
      end
      check("in_ready_accum", in_ready, 1);
      in_valid = 1'b1;
      in_data  = DW'(s[i]);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = $urandom;
    check("out_valid_latency", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("busy_done", busy, 1);
    for (int h = 0; h < hold; h++) begin
      start   = 1'($urandom_range(0, 1));
      win_len = 3;
      @(posedge Clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, exp_q[0].sum);
      check("hold_max", out_max, exp_q[0].mx);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    win_len   = 2;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_cleared", out_valid, 0);
    check("busy_cleared", busy, 0);
    check("in_ready_idle", in_ready, 0);
    @(posedge Clk); #1;
    check("idle_stays", busy, 0);
  endtask

  initial begin
    longint unsigned q[$];
    int              gq[$];

    Rst = 1'b0; start = 1'b1; win_len = 5; in_valid = 1'b1; in_data = 32'h1234;
    out_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    start = 1'b0; in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;

    q = {64'd10, 64'd300, 64'd7, 64'd65545};
    run_window(4, q, noq, 0, 0);

    q = {64'd5, 64'd6, 64'd9}; gq = {0, 2, 1};
    run_window(3, q, gq, 0, 5);

    @(posedge Clk); #1;
    start = 1'b1; win_len = 0;
    @(posedge Clk); #1;
    start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    @(posedge Clk); #1;
    check("len0_busy_later", busy, 0);

    q = {64'hFFFF_FFFF, 64'd2};
    run_window(2, q, noq, 0, 1);

    @(posedge Clk); #1;
    start = 1'b1; win_len = 5;
    @(posedge Clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 11;
    @(posedge Clk); #1;
    in_data = 12;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_out_sum", out_sum, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    q = {64'd42};
    run_window(1, q, noq, 0, 0);

    for (int w = 0; w < 25; w++) begin
      int len;
      len = $urandom_range(1, 12);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 1) ? longint'($urandom) : longint'($urandom_range(0, 1000)));
      run_window(len, q, noq, 2, $urandom_range(0, 3));
    end

    q.delete();
    for (int i = 0; i < 200; i++) q.push_back(longint'($urandom_range(0, 100000)));
    run_window(200, q, noq, 0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
